// File: rtl/divisor_restoring_param_if.sv
`default_nettype none
// ============================================================================
// Module      : divisor_restoring_param_if
// Description : Request/response bundle for the restoring divider.
//               master : issues start/signed_op/A_in/B_in, observes results
//               slave  : the divider itself
//   start      request, sampled only while busy=0
//   signed_op  two's-complement operation when 1
//   A_in/B_in  dividend / divisor (WIDTH bits)
//   busy       operation in flight
//   Q/R        quotient / remainder, held until the next done
//   done       one-cycle completion pulse
//   div0       divide-by-zero flag, same timing as Q/R
// Revision    : 1.0  initial release
// ============================================================================
interface divisor_restoring_param_if #(
  parameter int WIDTH = 7
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             busy;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             done;
  logic             div0;

  modport master (
    output start, signed_op, A_in, B_in,
    input  busy, Q, R, done, div0
  );

  modport slave (
    input  start, signed_op, A_in, B_in,
    output busy, Q, R, done, div0
  );
endinterface
`default_nettype wire

// File: rtl/divisor_restoring_param.sv
`default_nettype none
// ============================================================================
// Module      : divisor_restoring_param
// Description : Parametrised multi-cycle restoring divider with per-operation
//               signed/unsigned mode and divide-by-zero reporting.
//   clk   in  system clock, rising edge
//   rst   in  asynchronous reset, active-high
//   bus   slave modport of divisor_restoring_param_if (start, signed_op,
//         A_in, B_in in; busy, Q, R, done, div0 out)
// Revision    : 1.0  initial release
// ============================================================================
module divisor_restoring_param #(
  parameter int WIDTH     = 7,
  parameter bit SIGNED_EN = 1'b1
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  divisor_restoring_param_if.slave      bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Holds |A| while dividing; quotient bits shift in from the LSB as the
  // dividend bits shift out of the MSB. Holds raw A_in on the div0 path.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             div0_q, div0_d;

  logic             w_sa, w_sb;
  logic [WIDTH-1:0] w_absa, w_absb;
  logic [WIDTH:0]   w_shift, w_trial;
  logic             w_ge;

  always_comb begin
    w_sa   = SIGNED_EN && bus.signed_op && bus.A_in[WIDTH-1];
    w_sb   = SIGNED_EN && bus.signed_op && bus.B_in[WIDTH-1];
    // Negating the most-negative value yields 2^(WIDTH-1), which is the
    // correct magnitude when read as unsigned.
    w_absa = w_sa ? (WIDTH'(0) - bus.A_in) : bus.A_in;
    w_absb = w_sb ? (WIDTH'(0) - bus.B_in) : bus.B_in;

    w_shift = {rem_q, quo_q[WIDTH-1]};
    w_trial = w_shift - {1'b0, dvs_q};
    w_ge    = (w_shift >= {1'b0, dvs_q});

    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          rem_d  = '0;
          dvs_d  = w_absb;
          negq_d = w_sa ^ w_sb;
          negr_d = w_sa;
          if (bus.B_in == '0) begin
            dz_d    = 1'b1;
            quo_d   = bus.A_in;
            state_d = S_FIN;
          end else begin
            dz_d    = 1'b0;
            quo_d   = w_absa;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        // The partial remainder is always below the divisor, so the kept
        // value fits in WIDTH bits either way.
        rem_d = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], w_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (dz_q) begin
          q_d    = '1;
          r_d    = quo_q;
          div0_d = 1'b1;
        end else begin
          // Most-negative / -1 wraps naturally to most-negative here.
          q_d    = negq_q ? (WIDTH'(0) - quo_q) : quo_q;
          r_d    = negr_q ? (WIDTH'(0) - rem_q) : rem_q;
          div0_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.div0 = div0_q;

endmodule
`default_nettype wire
